// File: rtl/pht_update_scheduler.sv
// PHT update scheduler: sweeps the table to weakly-taken after reset, then queues
// resolved-branch updates from two issue ports and drains them through one write port.
module pht_update_scheduler #(
    parameter int ENTRY_NUM = 256,
    parameter int CNT_W     = 2,
    parameter int QDEPTH    = 4,
    localparam int IDX_W    = $clog2(ENTRY_NUM),
    localparam int QW       = $clog2(QDEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_taken,
    input  logic [1:0][IDX_W-1:0]      req_index,
    input  logic [1:0][CNT_W-1:0]      req_prev,
    output logic                       req_ready,
    output logic                       pht_we,
    output logic [IDX_W-1:0]           pht_wa,
    output logic [CNT_W-1:0]           pht_wv,
    output logic                       init_busy,
    output logic [QW:0]                q_count,
    output logic [7:0]                 drop_count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] INIT_VAL = (CNT_MAX >> 1) + CNT_W'(1);
    localparam logic [QW:0]      QDEPTH_V = (QW+1)'(QDEPTH);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [CNT_W-1:0] prev;
    } entry_t;

    state_t           state, stateNext;
    logic [IDX_W-1:0] sweepIdx;
    entry_t           queue [QDEPTH];
    logic [QW-1:0]    wrPtr, rdPtr;
    logic [QW:0]      count;
    logic [7:0]       dropCnt;

    logic             acc0, acc1, deq;
    logic [1:0]       nEnq, nDrop;
    logic [8:0]       dropSum;
    entry_t           head, entry0, entry1;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        init_busy = (state == INIT);
        req_ready = 1'b0;
        pht_we    = 1'b0;
        pht_wa    = '0;
        pht_wv    = '0;
        head      = queue[rdPtr];
        deq       = 1'b0;
        case (state)
            INIT: begin
                pht_we = 1'b1;
                pht_wa = sweepIdx;
                pht_wv = INIT_VAL;
                if (sweepIdx == IDX_W'(ENTRY_NUM - 1)) stateNext = RUN;
            end
            RUN: begin
                // Readiness is judged on last cycle's occupancy so a pair always fits.
                req_ready = (QDEPTH_V - count) >= (QW+1)'(2);
                deq       = (count != '0) && !flush;
                if (deq) begin
                    pht_we = 1'b1;
                    pht_wa = head.idx;
                    if (head.taken) pht_wv = (head.prev == CNT_MAX) ? CNT_MAX : head.prev + CNT_W'(1);
                    else            pht_wv = (head.prev == '0) ? '0 : head.prev - CNT_W'(1);
                end
            end
            default: stateNext = INIT;
        endcase
    end

    // Port 1 loses to port 0 on an index collision so the table sees one update.
    always_comb begin
        acc0    = req_valid[0] && req_ready && !flush;
        acc1    = req_valid[1] && req_ready && !flush && !(acc0 && req_index[0] == req_index[1]);
        nEnq    = {1'b0, acc0} + {1'b0, acc1};
        nDrop   = {1'b0, req_valid[0] && !acc0} + {1'b0, req_valid[1] && !acc1};
        dropSum = {1'b0, dropCnt} + 9'(nDrop);
        entry0  = '{idx: req_index[0], taken: req_taken[0], prev: req_prev[0]};
        entry1  = '{idx: req_index[1], taken: req_taken[1], prev: req_prev[1]};
    end

    always_ff @(posedge clk) begin
        if (acc0) queue[wrPtr] <= entry0;
        if (acc1) queue[wrPtr + QW'(acc0)] <= entry1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweepIdx <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            dropCnt  <= '0;
        end else begin
            if (state == INIT) sweepIdx <= sweepIdx + IDX_W'(1);
            dropCnt <= (dropSum > 9'd255) ? 8'hFF : dropSum[7:0];
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                wrPtr <= wrPtr + QW'(nEnq);
                rdPtr <= rdPtr + QW'(deq);
                count <= count + (QW+1)'(nEnq) - (QW+1)'(deq);
            end
        end
    end

    assign q_count    = count;
    assign drop_count = dropCnt;

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench for pht_update_scheduler: init sweep, counter update rules,
// collision drop, back-pressure ordering, flush and mid-sweep reset.
module tb_pht_update_scheduler;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic [1:0]       req_valid, req_taken;
    logic [1:0][7:0]  req_index;
    logic [1:0][1:0]  req_prev;
    logic             req_ready, pht_we, init_busy;
    logic [7:0]       pht_wa, drop_count;
    logic [1:0]       pht_wv;
    logic [2:0]       q_count;

    int nChecks = 0;
    int nFails  = 0;

    pht_update_scheduler #(.ENTRY_NUM(256), .CNT_W(2), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_taken(req_taken),
        .req_index(req_index), .req_prev(req_prev),
        .req_ready(req_ready), .pht_we(pht_we), .pht_wa(pht_wa), .pht_wv(pht_wv),
        .init_busy(init_busy), .q_count(q_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_taken = '0;
        req_index = '0;
        req_prev  = '0;
        flush     = 1'b0;
    endtask

    task automatic req(input logic [1:0] v, input int i0, input logic t0, input int p0,
                       input int i1, input logic t1, input int p1);
        req_valid    = v;
        req_index[0] = 8'(i0); req_taken[0] = t0; req_prev[0] = 2'(p0);
        req_index[1] = 8'(i1); req_taken[1] = t1; req_prev[1] = 2'(p1);
    endtask

    // Walks a full sweep starting from the current (index 0) cycle.
    task automatic sweepCheck();
        for (int i = 0; i < 256; i++) begin
            chk("sweep_wa", pht_wa, i);
            chk("sweep_we_wv", {pht_we, pht_wv}, {1'b1, 2'd2});
            tick(); #1;
        end
        chk("run_init_busy", init_busy, 0);
        chk("run_ready", req_ready, 1);
        chk("run_we", pht_we, 0);
        chk("run_wa_wv_idle", {pht_wa, pht_wv}, 0);
    endtask

    initial begin
        logic [7:0] expW [8];
        logic       expRdy [6];
        expW   = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd26, 8'd27, 8'd30, 8'd31};
        expRdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; idle();
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_init_busy", init_busy, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_drop", drop_count, 0);
        sweepCheck();

        // single updates with saturation / floor
        req(2'b01, 5, 1, 3, 0, 0, 0); #1;
        chk("nobypass_we", pht_we, 0);
        tick(); idle(); #1;
        chk("sat_we", pht_we, 1);
        chk("sat_wa", pht_wa, 5);
        chk("sat_wv", pht_wv, 3);
        chk("sat_qcount", q_count, 1);
        tick(); #1;
        chk("drained_we", pht_we, 0);
        chk("drained_qcount", q_count, 0);
        req(2'b01, 6, 0, 0, 0, 0, 0);
        tick(); idle(); #1;
        chk("floor_wa", pht_wa, 6);
        chk("floor_wv", pht_wv, 0);
        req(2'b11, 10, 1, 1, 11, 0, 2);
        tick(); idle(); #1;
        chk("pair0_wa_wv", {pht_wa, pht_wv}, {8'd10, 2'd2});
        tick(); #1;
        chk("pair1_wa_wv", {pht_wa, pht_wv}, {8'd11, 2'd1});
        tick(); #1;

        // index collision between ports
        req(2'b11, 9, 1, 1, 9, 0, 3);
        tick(); idle(); #1;
        chk("coll_wa_wv", {pht_we, pht_wa, pht_wv}, {1'b1, 8'd9, 2'd2});
        chk("coll_qcount", q_count, 1);
        chk("coll_drop", drop_count, 1);
        tick(); #1;
        chk("coll_single", pht_we, 0);

        // both ports every cycle: back-pressure and ordering
        for (int k = 0; k < 6; k++) begin
            req(2'b11, 20 + 2*k, 1, 0, 21 + 2*k, 0, 2); #1;
            chk("bp_ready", req_ready, expRdy[k]);
            if (k == 2) chk("bp_qcount", q_count, 3);
            if (k >= 1) chk("bp_wr", {pht_we, pht_wa, pht_wv}, {1'b1, expW[k-1], 2'd1});
            tick();
        end
        idle(); #1;
        for (int c = 6; c < 9; c++) begin
            chk("bp_drain", {pht_we, pht_wa, pht_wv}, {1'b1, expW[c-1], 2'd1});
            tick(); #1;
        end
        chk("bp_empty_we", pht_we, 0);
        chk("bp_drop", drop_count, 5);

        // flush with three queued entries
        req(2'b11, 40, 1, 2, 41, 0, 1);
        tick(); req(2'b11, 42, 1, 0, 43, 1, 0); #1;
        chk("fl_pre_wa", {pht_we, pht_wa}, {1'b1, 8'd40});
        tick(); idle(); flush = 1'b1; #1;
        chk("fl_qcount3", q_count, 3);
        chk("fl_we_sup", {pht_we, pht_wa, pht_wv}, 0);
        tick(); flush = 1'b0; #1;
        chk("fl_qcount0", q_count, 0);
        chk("fl_we_after", pht_we, 0);
        chk("fl_drop_keep", drop_count, 5);
        flush = 1'b1; req(2'b11, 50, 1, 1, 51, 1, 1); #1;
        tick(); idle(); #1;
        chk("fl_req_drop", drop_count, 7);
        chk("fl_req_qcount", q_count, 0);
        chk("fl_req_we", pht_we, 0);

        // reset while in RUN with queued requests
        req(2'b11, 60, 1, 1, 61, 1, 1);
        tick(); idle(); rst = 1'b1; #1;
        chk("rr_qcount_pre", q_count, 2);
        tick(); rst = 1'b0; #1;
        chk("rr_qcount", q_count, 0);
        chk("rr_busy", init_busy, 1);
        chk("rr_drop", drop_count, 0);
        chk("rr_wa", {pht_we, pht_wa}, {1'b1, 8'd0});
        req(2'b11, 70, 1, 1, 71, 1, 1); #1;
        chk("init_ready", req_ready, 0);
        tick(); idle(); #1;
        chk("init_drop", drop_count, 2);
        chk("init_wa1", pht_wa, 1);
        for (int i = 1; i < 100; i++) tick();
        #1;
        chk("mid_wa100", pht_wa, 100);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        chk("mid_restart_busy", init_busy, 1);
        sweepCheck();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pht_update_scheduler.md
PHT_UPDATE_SCHEDULER -- requirements
Module: pht_update_scheduler

Interface
REQ-001 The module SHALL have parameter ENTRY_NUM, default 256, meaning number of PHT entries (power of two); IDX_W = log2(ENTRY_NUM).
REQ-002 The module SHALL have parameter CNT_W, default 2, meaning saturating counter width; CNT_MAX = 2^CNT_W - 1.
REQ-003 The module SHALL have parameter QDEPTH, default 4, meaning update queue depth (power of two, >= 2).
REQ-004 The module SHALL have port clk, input, 1, meaning sole clock; all state on posedge.
REQ-005 The module SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 The module SHALL have port flush, input, 1, meaning discard all queued updates.
REQ-007 The module SHALL have ports req_valid[2], req_taken[2], input, 1 each, meaning branch-result valid and resolved direction per issue port.
REQ-008 The module SHALL have port req_index[2], input, IDX_W each, meaning PHT index of the resolved branch.
REQ-009 The module SHALL have port req_prev[2], input, CNT_W each, meaning counter value read at prediction time.
REQ-010 The module SHALL have port req_ready, output, 1, meaning both issue ports may present requests this cycle.
REQ-011 The module SHALL have ports pht_we (1), pht_wa (IDX_W), pht_wv (CNT_W), outputs, meaning single PHT write port.
REQ-012 The module SHALL have port init_busy, output, 1, meaning PHT initialisation sweep in progress.
REQ-013 The module SHALL have ports q_count, output, log2(QDEPTH)+1, meaning queue occupancy; and drop_count, output, 8, meaning saturating count of discarded requests.

Function
REQ-014 The FSM SHALL have states INIT and RUN; rst forces INIT with sweep index 0.
REQ-015 In INIT, each cycle SHALL assert pht_we with pht_wa = sweep index and pht_wv = CNT_MAX/2+1 (2'b10 for CNT_W=2), then increment the index.
REQ-016 The cycle writing index ENTRY_NUM-1 SHALL be the last INIT cycle; the next cycle SHALL be RUN.
REQ-017 init_busy SHALL equal (state == INIT); req_ready SHALL be 0 in INIT.
REQ-018 In RUN, req_ready SHALL be 1 iff free slots >= 2, computed from registered occupancy before this cycle's dequeue.
REQ-019 A request on port i SHALL be accepted iff req_valid[i] && req_ready; req_valid with req_ready=0 SHALL be dropped and counted.
REQ-020 If both ports are accepted with equal req_index, only port 0 SHALL be enqueued; port 1 SHALL be dropped and counted.
REQ-021 Accepted requests SHALL be enqueued in port order (0 then 1) as {index, taken, prev}.
REQ-022 In RUN with a non-empty queue, pht_we SHALL be 1 and pht_wa = head index; the head SHALL be dequeued that cycle.
REQ-023 pht_wv SHALL be min(prev+1, CNT_MAX) if taken, else max(prev-1, 0), computed at CNT_W bits with no wrap.
REQ-024 A request accepted in cycle c into an empty queue SHALL be written in cycle c+1 (one-cycle latency, no bypass).
REQ-025 Enqueue and dequeue in the same cycle SHALL be allowed; q_count SHALL update by (enqueued - dequeued).
REQ-026 Queue pointers SHALL wrap modulo QDEPTH.
REQ-027 flush SHALL empty the queue at the next edge and suppress pht_we that cycle; requests presented with flush SHALL be dropped and counted.
REQ-028 drop_count SHALL saturate at 255, increment by the number of drops per cycle (0-2), and not be cleared by flush.
REQ-029 When pht_we=0, pht_wa and pht_wv SHALL be 0.

Reset
REQ-030 After rst: state=INIT, sweep index=0, queue empty, q_count=0, drop_count=0, init_busy=1, req_ready=0; pht_we=1, pht_wa=0 in the first cycle after reset.
REQ-031 rst asserted mid-sweep or in RUN SHALL restart the sweep from index 0 and discard queued requests.

Verification
REQ-032 Reset with ENTRY_NUM=256 -> 256 consecutive writes to indices 0..255 with value 2; init_busy falls after the 256th write; req_ready=1 next cycle.
REQ-033 RUN, port0 {idx=5, taken=1, prev=3} -> next cycle pht_wa=5, pht_wv=3 (saturated); port0 {idx=6, taken=0, prev=0} -> pht_wv=0.
REQ-034 Both ports valid, idx 9 on both -> one write to 9 from port 0's data; drop_count increments by 1.
REQ-035 Both ports valid every cycle, distinct indices, QDEPTH=4 -> req_ready toggles to 0 once q_count > 2; no write lost; accepted writes appear in port order.
REQ-036 Queue holds 3 entries, flush asserted -> pht_we=0 that cycle, q_count=0 next cycle, drop_count unchanged unless requests were presented with flush.
REQ-037 rst asserted at sweep index 100 -> next write is index 0 and the full 256-entry sweep repeats.
